dcache_write_buffer: RTL and testbench

//  Write buffer between data cache and sram_axi write port (d_w*). Queues dirty-line evictions and

---
 rtl/dcache_write_buffer_pkg.sv | 23 ++
 rtl/dcache_write_buffer_line_addr_cam.sv | 24 ++
 rtl/dcache_write_buffer.sv | 152 +++++++++++++++
 tb/tb_dcache_write_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// rtl/dcache_write_buffer_pkg.sv - shared widths, AXI encodings and entry type for the dcache write buffer
package dcache_write_buffer_pkg;

  localparam int LINE_W = 512;
  localparam int OFF_W  = 6;
  localparam int LA_W   = 32 - OFF_W;

  localparam logic [7:0] WLEN_LINE = 8'd15;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [3:0]        strb;
  } wb_entry_t;

  function automatic logic [LA_W-1:0] line_addr(input logic [31:0] addr);
    return addr[31:OFF_W];
  endfunction

endpackage

// File: rtl/dcache_write_buffer_line_addr_cam.sv
// rtl/dcache_write_buffer_line_addr_cam.sv - DEPTH-way line-address comparator with per-entry valid mask
module dcache_write_buffer_line_addr_cam
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][LA_W-1:0] i_entry_la,
  input  logic [DEPTH-1:0]           i_mask,
  input  logic [LA_W-1:0]            i_query_la,
  output logic [DEPTH-1:0]           o_hit,
  output logic                       o_any
);

  // Per-entry compare; masked-off entries can never hit.
  always_comb begin
    o_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit[i] = i_mask[i] && (i_entry_la[i] == i_query_la);
    end
  end

  assign o_any = |o_hit;

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - in-order eviction/store queue between data cache and AXI write bridge
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              c_wvalid,
  output logic              c_wready,
  input  logic [31:0]       c_waddr,
  input  logic [LINE_W-1:0] c_wdata,
  input  logic [7:0]        c_wlen,
  input  logic [2:0]        c_wsize,
  input  logic [3:0]        c_wstrb,
  input  logic [31:0]       c_raddr,
  input  logic              c_rvalid,
  output logic              r_conflict,
  output logic [31:0]       d_waddr,
  output logic [LINE_W-1:0] d_wdata,
  output logic [7:0]        d_wlen,
  output logic [2:0]        d_wsize,
  output logic [3:0]        d_wstrb,
  output logic              d_wvalid,
  input  logic              d_wready,
  output logic              wb_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_entry_t        r_entry [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0][LA_W-1:0] w_entry_la;
  logic [DEPTH-1:0]           w_full_line;
  logic [DEPTH-1:0]           w_head_1h;
  logic [DEPTH-1:0]           w_merge_mask;
  logic [DEPTH-1:0]           w_merge_hit;
  logic [DEPTH-1:0]           w_rd_hit;
  logic                       w_merge_any;
  logic                       w_rd_any;
  logic [PTR_W-1:0]           w_merge_idx;
  logic                       w_nonempty;
  logic                       w_push;
  logic                       w_merge;
  logic                       w_append;
  logic                       w_pop;
  wb_entry_t                  w_head;
  wb_entry_t                  w_new;
  logic                       w_unused_raddr_bits;

  assign w_unused_raddr_bits = ^c_raddr[OFF_W-1:0];

  assign w_nonempty = (r_count != '0);
  assign w_push     = c_wvalid & c_wready;
  assign w_merge    = w_push & (c_wlen == WLEN_LINE) & w_merge_any;
  assign w_append   = w_push & ~w_merge;
  assign w_pop      = d_wready & w_nonempty;

  assign w_new = '{addr: c_waddr, data: c_wdata, len: c_wlen, size: c_wsize, strb: c_wstrb};

  // Per-entry line address, full-line flag and head marker feeding both CAM lookups.
  always_comb begin
    w_entry_la  = '0;
    w_full_line = '0;
    w_head_1h   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_la[i]  = line_addr(r_entry[i].addr);
      w_full_line[i] = (r_entry[i].len == WLEN_LINE);
    end
    w_head_1h[r_rd_ptr] = w_nonempty;
  end

  // The head is excluded: the bridge may already have latched its data.
  assign w_merge_mask = r_valid & w_full_line & ~w_head_1h;

  dcache_write_buffer_line_addr_cam #(.DEPTH(DEPTH)) u_rd_cam (
    .i_entry_la (w_entry_la),
    .i_mask     (r_valid),
    .i_query_la (line_addr(c_raddr)),
    .o_hit      (w_rd_hit),
    .o_any      (w_rd_any)
  );

  dcache_write_buffer_line_addr_cam #(.DEPTH(DEPTH)) u_merge_cam (
    .i_entry_la (w_entry_la),
    .i_mask     (w_merge_mask),
    .i_query_la (line_addr(c_waddr)),
    .o_hit      (w_merge_hit),
    .o_any      (w_merge_any)
  );

  // Merges never create duplicate lines, so at most one bit is set; lowest index wins regardless.
  always_comb begin
    w_merge_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_merge_hit[i]) w_merge_idx = PTR_W'(i);
    end
  end

  // Queue bookkeeping: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_append) begin
        r_wr_ptr           <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr]  <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr           <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr]  <= 1'b0;
      end
      case ({w_append, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage; a merge only refreshes data and strobe of a queued full line.
  always_ff @(posedge aclk) begin
    if (w_append) begin
      r_entry[r_wr_ptr] <= w_new;
    end else if (w_merge) begin
      r_entry[w_merge_idx].data <= c_wdata;
      r_entry[w_merge_idx].strb <= c_wstrb;
    end
  end

  assign w_head = r_entry[r_rd_ptr];

  assign c_wready   = (r_count != CNT_FULL);
  assign d_wvalid   = w_nonempty;
  assign wb_empty   = ~w_nonempty;
  assign d_waddr    = w_nonempty ? w_head.addr : '0;
  assign d_wdata    = w_nonempty ? w_head.data : '0;
  assign d_wlen     = w_nonempty ? w_head.len  : '0;
  assign d_wsize    = w_nonempty ? w_head.size : '0;
  assign d_wstrb    = w_nonempty ? w_head.strb : '0;
  assign r_conflict = c_rvalid & w_rd_any;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - scoreboard testbench for dcache_write_buffer
`timescale 1ns/1ps
module tb_dcache_write_buffer;
  import dcache_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              c_wvalid = 1'b0;
  logic              c_wready;
  logic [31:0]       c_waddr = '0;
  logic [LINE_W-1:0] c_wdata = '0;
  logic [7:0]        c_wlen = '0;
  logic [2:0]        c_wsize = '0;
  logic [3:0]        c_wstrb = '0;
  logic [31:0]       c_raddr = '0;
  logic              c_rvalid = 1'b0;
  logic              r_conflict;
  logic [31:0]       d_waddr;
  logic [LINE_W-1:0] d_wdata;
  logic [7:0]        d_wlen;
  logic [2:0]        d_wsize;
  logic [3:0]        d_wstrb;
  logic              d_wvalid;
  logic              d_wready = 1'b0;
  logic              wb_empty;

  wb_entry_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  dcache_write_buffer #(.DEPTH(DEPTH)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .c_wvalid   (c_wvalid),
    .c_wready   (c_wready),
    .c_waddr    (c_waddr),
    .c_wdata    (c_wdata),
    .c_wlen     (c_wlen),
    .c_wsize    (c_wsize),
    .c_wstrb    (c_wstrb),
    .c_raddr    (c_raddr),
    .c_rvalid   (c_rvalid),
    .r_conflict (r_conflict),
    .d_waddr    (d_waddr),
    .d_wdata    (d_wdata),
    .d_wlen     (d_wlen),
    .d_wsize    (d_wsize),
    .d_wstrb    (d_wstrb),
    .d_wvalid   (d_wvalid),
    .d_wready   (d_wready),
    .wb_empty   (wb_empty)
  );

  function automatic wb_entry_t mk(input logic [31:0] a, input logic [7:0] len, input logic [3:0] strb);
    wb_entry_t e;
    e.addr = a;
    e.len  = len;
    e.size = SIZE_WORD;
    e.strb = strb;
    for (int w = 0; w < LINE_W / 32; w++) e.data[32*w +: 32] = $urandom();
    return e;
  endfunction

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Reference queue update: a full line merges into a matching non-head full line, else appends.
  task automatic model_push(input wb_entry_t e);
    bit done;
    wb_entry_t t;
    done = 1'b0;
    if (e.len == WLEN_LINE) begin
      for (int i = 1; i < sb.size(); i++) begin
        if (!done && sb[i].len == WLEN_LINE && sb[i].addr[31:OFF_W] == e.addr[31:OFF_W]) begin
          t = sb[i];
          t.data = e.data;
          t.strb = e.strb;
          sb[i] = t;
          done = 1'b1;
        end
      end
    end
    if (!done) sb.push_back(e);
  endtask

  // One clock of stimulus: optional push and retire pulse; returns presented head and expected head.
  task automatic step(input bit do_push, input wb_entry_t e, input bit do_pop,
                      output wb_entry_t got, output wb_entry_t exp);
    bit had;
    c_wvalid = do_push;
    c_waddr  = e.addr;
    c_wdata  = e.data;
    c_wlen   = e.len;
    c_wsize  = e.size;
    c_wstrb  = e.strb;
    d_wready = do_pop;
    #1;
    had = (sb.size() > 0);
    got = {d_waddr, d_wdata, d_wlen, d_wsize, d_wstrb};
    exp = '0;
    if (do_push && sb.size() < DEPTH) model_push(e);
    if (do_pop && had) exp = sb.pop_front();
    @(posedge aclk);
    #1;
    c_wvalid = 1'b0;
    d_wready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn  = 1'b0;
    c_rvalid = 1'b1;
    c_raddr  = 32'h1C00_0040;
    tick();
    tick();
    n_vec++; if (d_wvalid !== 1'b0) begin n_err++; $display("FAIL reset_d_wvalid: got %b want 0", d_wvalid); end
    n_vec++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL reset_wb_empty: got %b want 1", wb_empty); end
    n_vec++; if (c_wready !== 1'b1) begin n_err++; $display("FAIL reset_c_wready: got %b want 1", c_wready); end
    n_vec++; if (r_conflict !== 1'b0) begin n_err++; $display("FAIL reset_r_conflict: got %b want 0", r_conflict); end
    n_vec++;
    if ({d_waddr, d_wlen, d_wsize, d_wstrb} !== 47'd0 || d_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_d_fields: got addr=%h len=%h size=%h strb=%h want all zero", d_waddr, d_wlen, d_wsize, d_wstrb);
    end
    aresetn  = 1'b1;
    c_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_first_push;
    wb_entry_t e, got, exp;
    e = mk(32'h1C00_0040, WLEN_LINE, 4'hF);
    step(1'b1, e, 1'b0, got, exp);
    n_vec++; if (d_wvalid !== 1'b1) begin n_err++; $display("FAIL first_d_wvalid: got %b want 1", d_wvalid); end
    n_vec++; if (wb_empty !== 1'b0) begin n_err++; $display("FAIL first_wb_empty: got %b want 0", wb_empty); end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (d_waddr !== 32'h1C00_0040 || d_wlen !== WLEN_LINE) begin
        n_err++;
        $display("FAIL first_hold%0d: got addr=%h len=%h want addr=1c000040 len=0f", k, d_waddr, d_wlen);
      end
      tick();
    end
    step(1'b0, e, 1'b1, got, exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL first_head: got addr=%h len=%h strb=%h d0=%h want addr=%h len=%h strb=%h d0=%h",
               got.addr, got.len, got.strb, got.data[63:0], exp.addr, exp.len, exp.strb, exp.data[63:0]);
    end
    n_vec++; if (d_wvalid !== 1'b0) begin n_err++; $display("FAIL first_drained: got d_wvalid=%b want 0", d_wvalid); end
  endtask

  task automatic test_full;
    wb_entry_t e, e5, got, exp;
    for (int i = 0; i < DEPTH; i++) begin
      e = mk(32'h1000 * (i + 1), WLEN_LINE, 4'hF);
      step(1'b1, e, 1'b0, got, exp);
      n_vec++;
      if (c_wready !== (i < DEPTH - 1)) begin
        n_err++;
        $display("FAIL full_wready%0d: got %b want %b", i, c_wready, (i < DEPTH - 1));
      end
    end
    e5 = mk(32'h5004, 8'd0, 4'h3);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, e5, 1'b0, got, exp);
      n_vec++;
      if (c_wready !== 1'b0 || d_waddr !== 32'h1000) begin
        n_err++;
        $display("FAIL full_hold%0d: got wready=%b addr=%h want wready=0 addr=00001000", k, c_wready, d_waddr);
      end
    end
    step(1'b1, e5, 1'b1, got, exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL full_pop: got addr=%h len=%h want addr=%h len=%h", got.addr, got.len, exp.addr, exp.len);
    end
    n_vec++; if (c_wready !== 1'b1) begin n_err++; $display("FAIL full_reopen: got wready=%b want 1", c_wready); end
    step(1'b1, e5, 1'b0, got, exp);
    for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
      step(1'b0, e5, 1'b1, got, exp);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL full_drain%0d: got addr=%h len=%h strb=%h d0=%h want addr=%h len=%h strb=%h d0=%h",
                 k, got.addr, got.len, got.strb, got.data[63:0], exp.addr, exp.len, exp.strb, exp.data[63:0]);
      end
    end
    n_vec++; if (d_wvalid !== 1'b0) begin n_err++; $display("FAIL full_empty: got d_wvalid=%b want 0", d_wvalid); end
  endtask

  task automatic test_merge;
    wb_entry_t a, b, a2, b2, c, got, exp;
    a  = mk(32'h100, WLEN_LINE, 4'hF);
    b  = mk(32'h200, WLEN_LINE, 4'hF);
    a2 = mk(32'h100, WLEN_LINE, 4'hE);
    b2 = mk(32'h200, WLEN_LINE, 4'h7);
    c  = mk(32'h300, WLEN_LINE, 4'hF);
    step(1'b1, a, 1'b0, got, exp);
    step(1'b1, b, 1'b0, got, exp);
    step(1'b1, a2, 1'b0, got, exp);
    step(1'b1, b2, 1'b0, got, exp);
    n_vec++; if (c_wready !== 1'b1) begin n_err++; $display("FAIL merge_count3: got wready=%b want 1", c_wready); end
    step(1'b1, c, 1'b0, got, exp);
    n_vec++; if (c_wready !== 1'b0) begin n_err++; $display("FAIL merge_count4: got wready=%b want 0", c_wready); end
    for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
      step(1'b0, c, 1'b1, got, exp);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL merge_drain%0d: got addr=%h strb=%h d0=%h want addr=%h strb=%h d0=%h",
                 k, got.addr, got.strb, got.data[63:0], exp.addr, exp.strb, exp.data[63:0]);
      end
    end
    n_vec++; if (d_wvalid !== 1'b0) begin n_err++; $display("FAIL merge_empty: got d_wvalid=%b want 0", d_wvalid); end
  endtask

  task automatic test_conflict;
    wb_entry_t a, b, got, exp;
    a = mk(32'h100, WLEN_LINE, 4'hF);
    b = mk(32'h200, WLEN_LINE, 4'hF);
    step(1'b1, a, 1'b0, got, exp);
    step(1'b1, b, 1'b0, got, exp);
    c_rvalid = 1'b1; c_raddr = 32'h0000_0234; #1;
    n_vec++; if (r_conflict !== 1'b1) begin n_err++; $display("FAIL conf_b: got %b want 1", r_conflict); end
    c_raddr = 32'h0000_0104; #1;
    n_vec++; if (r_conflict !== 1'b1) begin n_err++; $display("FAIL conf_head: got %b want 1", r_conflict); end
    c_raddr = 32'h0000_0300; #1;
    n_vec++; if (r_conflict !== 1'b0) begin n_err++; $display("FAIL conf_miss: got %b want 0", r_conflict); end
    c_rvalid = 1'b0; c_raddr = 32'h0000_0234; #1;
    n_vec++; if (r_conflict !== 1'b0) begin n_err++; $display("FAIL conf_novalid: got %b want 0", r_conflict); end
    c_rvalid = 1'b1;
    step(1'b0, a, 1'b1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL conf_pop_a: got addr=%h want addr=%h", got.addr, exp.addr); end
    n_vec++; if (r_conflict !== 1'b1) begin n_err++; $display("FAIL conf_b_still: got %b want 1", r_conflict); end
    step(1'b0, a, 1'b1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL conf_pop_b: got addr=%h want addr=%h", got.addr, exp.addr); end
    n_vec++; if (r_conflict !== 1'b0) begin n_err++; $display("FAIL conf_retired: got %b want 0", r_conflict); end
    c_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back;
    wb_entry_t e, got, exp;
    step(1'b1, mk(32'h8000, WLEN_LINE, 4'hF), 1'b0, got, exp);
    step(1'b1, mk(32'h8040, 8'd0, 4'h1), 1'b0, got, exp);
    for (int i = 0; i < 6; i++) begin
      e = mk(32'h9000 + 32'h40 * i, (i % 2 == 0) ? WLEN_LINE : 8'd0, 4'(i + 2));
      step(1'b1, e, 1'b1, got, exp);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_head%0d: got addr=%h len=%h strb=%h want addr=%h len=%h strb=%h",
                 i, got.addr, got.len, got.strb, exp.addr, exp.len, exp.strb);
      end
      n_vec++;
      if (d_wvalid !== 1'b1 || c_wready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_state%0d: got wvalid=%b wready=%b want 1 1", i, d_wvalid, c_wready);
      end
    end
    for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
      step(1'b0, e, 1'b1, got, exp);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_drain%0d: got addr=%h len=%h want addr=%h len=%h", k, got.addr, got.len, exp.addr, exp.len);
      end
    end
    n_vec++; if (d_wvalid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got d_wvalid=%b want 0", d_wvalid); end
  endtask

  task automatic test_reset_mid;
    wb_entry_t e, got, exp;
    for (int i = 0; i < 3; i++) step(1'b1, mk(32'hA000 + 32'h40 * i, WLEN_LINE, 4'hF), 1'b0, got, exp);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    sb.delete();
    n_vec++;
    if (d_wvalid !== 1'b0 || wb_empty !== 1'b1 || c_wready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid: got wvalid=%b empty=%b wready=%b want 0 1 1", d_wvalid, wb_empty, c_wready);
    end
    tick();
    tick();
    n_vec++; if (d_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale: got d_wvalid=%b want 0", d_wvalid); end
    e = mk(32'hB000, 8'd0, 4'h5);
    step(1'b0, e, 1'b1, got, exp);
    step(1'b1, e, 1'b0, got, exp);
    step(1'b0, e, 1'b1, got, exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rst_mid_new: got addr=%h len=%h strb=%h want addr=%h len=%h strb=%h",
               got.addr, got.len, got.strb, exp.addr, exp.len, exp.strb);
    end
    n_vec++; if (d_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_end: got d_wvalid=%b want 0", d_wvalid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_push();
    test_full();
    test_merge();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
